lsu_dmem_port: RTL
==================

Name: lsu_dmem_port

Overview:
- Memory-side stage directly downstream of the LSU functional unit; consumes its one-cycle mem_ren / mem_wen requests.
- Posts stores into a WB_DEPTH-entry write buffer and forwards buffered store data to matching loads.
- Serialises load misses and store drains onto a single req/ack data-memory bus.
- Provides mem_busy back-pressure. The LSU must not issue a request while mem_busy is high.

Parameters:
WB_DEPTH, 4, write-buffer entries (power of two, >=2)
ADDR_BITS, 64, address width on LSU and bus sides

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_ren  in  1  load request pulse from LSU
mem_raddr  in  ADDR_BITS  load address
mem_rvalid  out  1  load data valid, one-cycle pulse
mem_rdata  out  64  load data
mem_wen  in  1  store request pulse from LSU
mem_waddr  in  ADDR_BITS  store address
mem_wdata  in  64  store data
mem_busy  out  1  LSU must not assert mem_ren/mem_wen while high
bus_req  out  1  bus request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  ADDR_BITS  bus address
bus_wdata  out  64  bus write data
bus_ack  in  1  one-cycle completion from memory
bus_rdata  in  64  read data, valid with bus_ack

Behaviour:
Access model
- All accesses are aligned 64-bit doublewords.
- Address match is an exact compare over all ADDR_BITS bits.

Reset
- Write buffer empty, pointers and count 0, read pending cleared, FSM in IDLE.
- All outputs 0.
- Reset mid-transaction drops bus_req asynchronously. The bus slave must tolerate this.

Write buffer
- FIFO with head/tail pointers that wrap modulo WB_DEPTH, plus a count.
- mem_wen pushes {waddr, wdata} at the tail.
- Push and pop in the same cycle leave count unchanged.

mem_busy
- Combinational from registered state: mem_busy = rd_pending | (count == WB_DEPTH).
- Stays high during a full-buffer cycle that also pops.
- mem_wen while full: ignored, entry not written, simulation assertion fires.
- mem_ren while rd_pending: ignored, assertion fires.

Load handling
- mem_ren sets rd_pending and latches the address.
- The address is compared against all valid buffer entries and against the same-cycle mem_wen. A same-cycle store counts as older than the load.
- Hit: mem_rvalid = 1 in the next cycle with the youngest matching data. No bus activity. rd_pending clears in that cycle.
- Miss: the load waits for the FSM and bypasses buffered stores. This is safe because exact-match forwarding covers every dependence under the aligned-doubleword model.

FSM (IDLE, RD, WR)
- IDLE: a pending miss goes to RD. Otherwise a non-empty buffer goes to WR. Loads have priority.
- RD: bus_req = 1, bus_we = 0, bus_addr = latched load address.
  - On bus_ack, register bus_rdata.
  - mem_rvalid pulses in the cycle after ack; rd_pending clears; return to IDLE.
- WR: bus_req = 1, bus_we = 1, address/data = buffer head.
  - On bus_ack, pop the head and return to IDLE.
- Bus rules:
  - bus_req and bus_addr/bus_wdata are registered and stay stable until ack.
  - bus_req is low for at least one cycle between transactions (IDLE cycle).
  - A write already in WR completes before a later miss is served; no abort.

Latency
- Forwarded load: 1 cycle.
- Miss with idle bus: 1 (IDLE to RD) + memory latency + 1.
- mem_rvalid is never asserted for a hit and a miss in the same cycle.

Test Plan:
- Reset, then mem_wen A=0x100/D=0xAA, bus_ack 2 cycles after bus_req -> one write transaction with bus_we=1, addr 0x100, data 0xAA; count returns to 0; mem_busy never high.
- 4 stores 0x0, 0x8, 0x10, 0x18 with bus_ack held low -> mem_busy high after the 4th; a 5th mem_wen is dropped (assertion); releasing acks drains in FIFO order; pointers wrap correctly on a further 4 stores.
- Store 0x40 = 1, then store 0x40 = 2, then mem_ren 0x40 with bus stalled -> mem_rvalid next cycle with mem_rdata = 2; no bus read issued.
- Same-cycle mem_wen 0x80 = 0x55 and mem_ren 0x80 -> mem_rvalid next cycle with 0x55.
- Buffer holds 0x200; mem_ren 0x300 (miss) with bus_rdata = 0xDEAD -> read goes out before the write drain; mem_rvalid with 0xDEAD the cycle after ack; the write follows.
- rst asserted while in RD with bus_req high -> bus_req, mem_rvalid, mem_busy go to 0 immediately; after release the buffer is empty and a new load completes normally.

Source files
------------

// File: rtl/lsu_dmem_port_if.sv
`default_nettype none
// ============================================================================
// Module     : lsu_dmem_port_if
// Description: Signal bundle between the LSU memory stage and the data-memory
//              bus. It carries the LSU request/response side and the
//              req/ack bus side.
//   LSU side : mem_ren, mem_raddr, mem_rvalid, mem_rdata,
//              mem_wen, mem_waddr, mem_wdata, mem_busy
//   Bus side : bus_req, bus_we, bus_addr, bus_wdata, bus_ack, bus_rdata
//   Modports : slave  - the lsu_dmem_port block
//              master - the environment (LSU plus memory)
// Revision   : 1.0 - initial release
// ============================================================================
interface lsu_dmem_port_if #(
    parameter int ADDR_BITS = 64
);
    logic                 mem_ren;
    logic [ADDR_BITS-1:0] mem_raddr;
    logic                 mem_rvalid;
    logic [63:0]          mem_rdata;
    logic                 mem_wen;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [63:0]          mem_wdata;
    logic                 mem_busy;
    logic                 bus_req;
    logic                 bus_we;
    logic [ADDR_BITS-1:0] bus_addr;
    logic [63:0]          bus_wdata;
    logic                 bus_ack;
    logic [63:0]          bus_rdata;

    modport slave (
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               bus_ack, bus_rdata,
        output mem_rvalid, mem_rdata, mem_busy,
               bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               bus_ack, bus_rdata,
        input  mem_rvalid, mem_rdata, mem_busy,
               bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dmem_port.sv
`default_nettype none
// ============================================================================
// Module     : lsu_dmem_port
// Description: Memory-side stage behind the LSU. Stores are posted into a
//              WB_DEPTH-entry FIFO write buffer, and loads that hit a buffered
//              (or same-cycle) store are forwarded in one cycle. Load misses
//              and store drains are serialised onto one req/ack memory bus,
//              with loads taking priority. mem_busy provides back-pressure.
// Ports      : clk - clock
//              rst - asynchronous active-high reset
//              io  - lsu_dmem_port_if.slave (LSU and bus signals)
// Revision   : 1.0 - initial release
// ============================================================================
module lsu_dmem_port #(
    parameter int WB_DEPTH  = 4,
    parameter int ADDR_BITS = 64
) (
    input  wire             clk,
    input  wire             rst,
    lsu_dmem_port_if.slave  io
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    // Write buffer storage (data path only, validity is tracked by count_q)
    logic [ADDR_BITS-1:0] wb_addr_q [WB_DEPTH];
    logic [63:0]          wb_data_q [WB_DEPTH];
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 rd_pending_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic                 rvalid_q;
    logic [63:0]          rdata_q;

    state_t               state_q, state_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [ADDR_BITS-1:0] bus_addr_q, bus_addr_d;
    logic [63:0]          bus_wdata_q, bus_wdata_d;

    logic                 wb_full;
    logic                 push;
    logic                 pop;
    logic                 ren_ok;
    logic                 rd_done;
    logic                 fwd_hit;
    logic [63:0]          fwd_data;

    assign wb_full = (count_q == FULL_CNT);
    assign push    = io.mem_wen & ~wb_full;
    assign ren_ok  = io.mem_ren & ~rd_pending_q;

    // Store-to-load forwarding. Entries are scanned oldest to youngest so the
    // last match wins; a same-cycle store is younger than every entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (wb_addr_q[head_q + PTR_W'(i)] == io.mem_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[head_q + PTR_W'(i)];
            end
        end
        if (push && (io.mem_waddr == io.mem_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = io.mem_wdata;
        end
    end

    // Bus FSM: next state and registered bus outputs. Bus fields are loaded
    // on leaving IDLE and held until ack; returning to IDLE guarantees a
    // low cycle on bus_req between transactions.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        pop         = 1'b0;
        rd_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_pending_q) begin
                    state_d     = S_RD;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = rd_addr_q;
                    bus_wdata_d = '0;
                end else if (count_q != '0) begin
                    state_d     = S_WR;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = wb_addr_q[head_q];
                    bus_wdata_d = wb_data_q[head_q];
                end
            end
            S_RD: begin
                if (io.bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    rd_done   = 1'b1;
                end
            end
            S_WR: begin
                if (io.bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    pop       = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rd_pending_q <= 1'b0;
            rd_addr_q    <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;

            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // A miss can only complete while one is pending, and a new load
            // is only accepted when none is, so these never collide.
            rvalid_q <= 1'b0;
            if (rd_done) begin
                rvalid_q     <= 1'b1;
                rdata_q      <= io.bus_rdata;
                rd_pending_q <= 1'b0;
            end
            if (ren_ok) begin
                if (fwd_hit) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= fwd_data;
                end else begin
                    rd_pending_q <= 1'b1;
                    rd_addr_q    <= io.mem_raddr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= io.mem_waddr;
            wb_data_q[tail_q] <= io.mem_wdata;
        end
    end

    assign io.mem_rvalid = rvalid_q;
    assign io.mem_rdata  = rdata_q;
    assign io.mem_busy   = rd_pending_q | wb_full;
    assign io.bus_req    = bus_req_q;
    assign io.bus_we     = bus_we_q;
    assign io.bus_addr   = bus_addr_q;
    assign io.bus_wdata  = bus_wdata_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(io.mem_wen && wb_full))
                else $error("lsu_dmem_port: store issued while write buffer full");
            assert (!(io.mem_ren && rd_pending_q))
                else $error("lsu_dmem_port: load issued while a load is pending");
        end
    end
`endif

endmodule
`default_nettype wire
